// File: rtl/i2c_master_ctrl.sv
`timescale 1ns/1ps
// Purpose  : single-register I2C master; turns write/read commands into SCL/SDA waveforms.
// Latency  : write 113*CLK_DIV clk and read 154*CLK_DIV clk from acceptance to the rsp_valid cycle.
// Backpres.: cmd_ready high only in IDLE; commands offered while busy are dropped, not queued.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (accepted on valid && ready)
//   cmd_rw, cmd_dev_adr,           0 = write / 1 = read, 7-bit device address,
//   cmd_reg_adr, cmd_wdata         register address, write data
//   rsp_valid, rsp_rdata, rsp_nack one-cycle response pulse, read data, NACK seen
//   busy                           inverse of cmd_ready
//   osck, osda                     SCL / SDA drive (1 = released)
//   isda                           SDA readback from the wired-AND bus
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_adr,
    input  logic [7:0] cmd_reg_adr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       osck,
    output logic       osda,
    input  logic       isda
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_RESP
    } state_t;

    state_t      state;
    logic [QW-1:0] qcnt;       // clk count within the current quarter
    logic [1:0]  quarter;      // q0..q3 within a bit or the STOP sequence
    logic [3:0]  bit_cnt;      // 0..8, bit 8 is the ACK slot
    logic [1:0]  byte_idx;     // byte within the current transaction
    logic        second;       // 1 = second (data-read) transaction of a read
    logic        nack_flag;
    logic [7:0]  tx_sh;        // remaining bits of the byte being sent, 1-filled
    logic [7:0]  rx_sh;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;

    logic        q_wrap;
    logic        rx_byte;
    logic        last_byte;
    logic [7:0]  dev_byte;
    logic [7:0]  nxt_byte;

    assign q_wrap    = (qcnt == Q_LAST);
    // Only the second byte of the read transaction is received from the slave.
    assign rx_byte   = second && (byte_idx == 2'd1);
    assign last_byte = (byte_idx == (rw_q ? 2'd1 : 2'd2));
    assign dev_byte  = {dev_q, second};
    // Byte following byte_idx; the received byte is sent as all-ones so the
    // slave owns SDA and the master's 9th bit becomes a NACK.
    assign nxt_byte  = (byte_idx == 2'd0) ? (second ? 8'hFF : reg_q) : wdata_q;
    assign busy      = ~cmd_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            quarter   <= 2'd0;
            bit_cnt   <= 4'd0;
            byte_idx  <= 2'd0;
            second    <= 1'b0;
            nack_flag <= 1'b0;
            tx_sh     <= 8'hFF;
            rx_sh     <= 8'h00;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
            osck      <= 1'b1;
            osda      <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rw_q      <= cmd_rw;
                        dev_q     <= cmd_dev_adr;
                        reg_q     <= cmd_reg_adr;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        second    <= 1'b0;
                        nack_flag <= 1'b0;
                        qcnt      <= '0;
                        osda      <= 1'b0;   // START: SDA falls while SCL high
                        state     <= S_START;
                    end
                end

                S_START: begin
                    if (q_wrap) begin
                        qcnt     <= '0;
                        quarter  <= 2'd0;
                        bit_cnt  <= 4'd0;
                        byte_idx <= 2'd0;
                        osck     <= 1'b0;
                        osda     <= dev_byte[7];
                        tx_sh    <= {dev_byte[6:0], 1'b1};
                        state    <= S_BIT;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                S_BIT: begin
                    if (q_wrap) begin
                        qcnt    <= '0;
                        quarter <= quarter + 2'd1;
                        case (quarter)
                            2'd1: osck <= 1'b1;
                            2'd2: begin
                                // Last clk of q2: mid-high-phase sample of the bus.
                                if (bit_cnt == 4'd8) begin
                                    if (!rx_byte && isda) nack_flag <= 1'b1;
                                end else if (rx_byte) begin
                                    rx_sh <= {rx_sh[6:0], isda};
                                end
                            end
                            2'd3: begin
                                osck <= 1'b0;
                                if (bit_cnt != 4'd8) begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    osda    <= tx_sh[7];
                                    tx_sh   <= {tx_sh[6:0], 1'b1};
                                end else if (nack_flag || last_byte) begin
                                    // Any NACK skips the rest of the transaction.
                                    osda  <= 1'b0;
                                    state <= S_STOP;
                                end else begin
                                    byte_idx <= byte_idx + 2'd1;
                                    bit_cnt  <= 4'd0;
                                    osda     <= nxt_byte[7];
                                    tx_sh    <= {nxt_byte[6:0], 1'b1};
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                S_STOP: begin
                    if (q_wrap) begin
                        qcnt    <= '0;
                        quarter <= quarter + 2'd1;
                        case (quarter)
                            2'd0: osck <= 1'b1;
                            2'd1: osda <= 1'b1;   // STOP: SDA rises while SCL high
                            2'd3: begin
                                if (rw_q && !second && !nack_flag) begin
                                    // STOP+START instead of a repeated START.
                                    second <= 1'b1;
                                    osda   <= 1'b0;
                                    state  <= S_START;
                                end else begin
                                    rsp_valid <= 1'b1;
                                    rsp_nack  <= nack_flag;
                                    if (rw_q && !nack_flag) rsp_rdata <= rx_sh;
                                    state     <= S_RESP;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                S_RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

    localparam int Q       = 16;
    localparam int START_T = 1000;
    localparam int STOP_T  = 1001;
    localparam logic [6:0] SLV_ADR = 7'h10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_adr = 7'h00;
    logic [7:0] cmd_reg_adr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, osck, osda;
    logic [7:0] rsp_rdata;
    logic       slv_sda = 1'b1;
    logic       isda;

    assign isda = osda & slv_sda;

    i2c_master_ctrl #(.CLK_DIV(Q)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev_adr(cmd_dev_adr), .cmd_reg_adr(cmd_reg_adr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .osck(osck), .osda(osda), .isda(isda)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        int         lat;
        int         acc;
    } rsp_t;

    rsp_t rsp_q[$];
    int   tok_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // ---------------- bus monitor + behavioural slave ----------------
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         bitn = 0, byte_cnt = 0;
    logic [7:0] sh = 8'h00;
    logic       addressed = 1'b0, reading = 1'b0;
    logic [7:0] slv_rdata = 8'h00;

    function automatic void bus_event(int tok);
        if (tok_q.size() == 0) chk("bus_extra_event", tok, -1);
        else chk("bus_event", tok, tok_q.pop_front());
    endfunction

    always @(negedge clk) begin
        logic sda_now;
        sda_now = osda & slv_sda;
        if (!rstn) begin
            bitn = 0; byte_cnt = 0; addressed = 1'b0; reading = 1'b0; slv_sda = 1'b1;
        end else if (prev_scl && osck && prev_sda && !sda_now) begin
            bus_event(START_T);
            bitn = 0; byte_cnt = 0; addressed = 1'b0; reading = 1'b0; slv_sda = 1'b1;
        end else if (prev_scl && osck && !prev_sda && sda_now) begin
            bus_event(STOP_T);
            slv_sda = 1'b1;
        end else if (!prev_scl && osck) begin
            if (bitn < 8) begin
                sh = {sh[6:0], sda_now};
                bitn++;
            end else begin
                bus_event(int'(sh) * 2 + int'(sda_now));
                if (byte_cnt == 0) begin
                    addressed = (sh[7:1] == SLV_ADR);
                    reading   = sh[0];
                end
                byte_cnt++;
                bitn = 0;
            end
        end else if (prev_scl && !osck) begin
            slv_sda = 1'b1;
            if (reading && addressed && byte_cnt == 1) begin
                if (bitn < 8) slv_sda = slv_rdata[7 - bitn];
            end else if (bitn == 8) begin
                if (byte_cnt == 0) slv_sda = !(sh[7:1] == SLV_ADR);
                else slv_sda = !addressed;
            end
        end
        prev_scl = osck;
        prev_sda = osda & slv_sda;
    end

    // ---------------- response monitor ----------------
    logic chk_next = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            chk_next = 1'b0;
        end else if (chk_next) begin
            chk("rsp_single_pulse", rsp_valid, 0);
            chk("ready_after_rsp", cmd_ready, 1);
            chk_next = 1'b0;
        end else if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_nack", rsp_nack, e.nack);
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
            chk_next = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_b(input logic [7:0] b, input logic a);
        tok_q.push_back(int'(b) * 2 + int'(a));
    endtask

    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic exp_on, input logic [7:0] exp_rdata,
                         input logic exp_nack, input int exp_lat);
        int   n;
        rsp_t e;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_adr = dev; cmd_reg_adr = rg; cmd_wdata = wd;
        @(posedge clk);
        #1;
        // Fields are scrambled after acceptance; the DUT must have captured them.
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_dev_adr = 7'h55; cmd_reg_adr = 8'hEE; cmd_wdata = 8'h77;
        if (exp_on) begin
            e.rdata = exp_rdata; e.nack = exp_nack; e.lat = exp_lat; e.acc = cyc;
            rsp_q.push_back(e);
        end
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout_pending_rsp", rsp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with cmd_valid asserted.
        rstn = 1'b0; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_osck", osck, 1);
        chk("rst_osda", osda, 1);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        rstn = 1'b1; cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x10/0x03 <- 0xA5.
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'h03, 0); push_b(8'hA5, 0); tok_q.push_back(STOP_T);
        issue(1'b0, 7'h10, 8'h03, 8'hA5, 1'b1, 8'h00, 1'b0, 113 * Q);
        wait_done();

        // Read 0x10/0x03, slave returns 0x5C.
        slv_rdata = 8'h5C;
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'h03, 0); tok_q.push_back(STOP_T);
        tok_q.push_back(START_T); push_b(8'h21, 0); push_b(8'h5C, 1); tok_q.push_back(STOP_T);
        issue(1'b1, 7'h10, 8'h03, 8'h00, 1'b1, 8'h5C, 1'b0, 154 * Q);
        wait_done();

        // Read from an absent device: NACK on address, read data unchanged.
        tok_q.push_back(START_T); push_b(8'h66, 1); tok_q.push_back(STOP_T);
        issue(1'b1, 7'h33, 8'h03, 8'h00, 1'b1, 8'h5C, 1'b1, 41 * Q);
        wait_done();

        // Write to an absent device.
        tok_q.push_back(START_T); push_b(8'h22, 1); tok_q.push_back(STOP_T);
        issue(1'b0, 7'h11, 8'h07, 8'hFF, 1'b1, 8'h5C, 1'b1, 41 * Q);
        wait_done();

        // Write with a competing command offered while busy.
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'h07, 0); push_b(8'h3C, 0); tok_q.push_back(STOP_T);
        issue(1'b0, 7'h10, 8'h07, 8'h3C, 1'b1, 8'h5C, 1'b0, 113 * Q);
        repeat (200) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_dev_adr = 7'h22; cmd_reg_adr = 8'h55; cmd_wdata = 8'h12;
        repeat (3) @(negedge clk);
        chk("ready_low_while_busy", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_done();

        // Second read pattern.
        slv_rdata = 8'hA3;
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'hC8, 0); tok_q.push_back(STOP_T);
        tok_q.push_back(START_T); push_b(8'h21, 0); push_b(8'hA3, 1); tok_q.push_back(STOP_T);
        issue(1'b1, 7'h10, 8'hC8, 8'h00, 1'b1, 8'hA3, 1'b0, 154 * Q);
        wait_done();

        // Reset during q0 of the third bit of the data byte (wdata 0x69, that bit is 1).
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'h40, 0);
        issue(1'b0, 7'h10, 8'h40, 8'h69, 1'b0, 8'h00, 1'b0, 0);
        repeat (81 * Q + 5) @(negedge clk);
        chk("osck_low_before_reset", osck, 0);
        chk("osda_bit_before_reset", osda, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_osck", osck, 1);
        chk("midrst_osda", osda, 1);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_rdata", rsp_rdata, 8'h00);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Normal write after the aborted one.
        tok_q.push_back(START_T); push_b(8'h20, 0); push_b(8'h11, 0); push_b(8'h96, 0); tok_q.push_back(STOP_T);
        issue(1'b0, 7'h10, 8'h11, 8'h96, 1'b1, 8'h00, 1'b0, 113 * Q);
        wait_done();

        chk("bus_tokens_left", tok_q.size(), 0);
        chk("responses_left", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Upstream stage of the on-chip I2C register slave. Turns single-register write/read commands from host-side FPGA logic into I2C bus waveforms.
- Drives SCL and SDA into the slave's isck/isda inputs and samples the slave's osda (wired-AND with this block's SDA output at board level).
- Runs one command at a time with a valid/ready command handshake and a one-cycle response pulse.

Parameters:
- CLK_DIV, 250, clk cycles per quarter bit-period Q (SCL period = 4*CLK_DIV). Legal range 16..4095 so the slave's sync and debounce settle.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
- cmd_rw  in  1  0 = register write, 1 = register read
- cmd_dev_adr  in  7  7-bit device address
- cmd_reg_adr  in  8  register address
- cmd_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse when the transaction finishes
- rsp_rdata  out  8  read data; valid with rsp_valid for reads; holds last value otherwise
- rsp_nack  out  1  valid with rsp_valid; 1 = some address/data byte was NACKed
- busy  out  1  ~cmd_ready
- osck  out  1  SCL, 1 = released/high
- osda  out  1  SDA, 1 = released/high
- isda  in  1  bus SDA readback (no internal synchroniser required; sampled mid-high-phase)

Behaviour:
- Reset, checked at any clk edge with rstn=0, including mid-transaction: osck=1, osda=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_rdata=8'h00. Counters return to 0 and the FSM to IDLE. No STOP is generated.
- Command fields are captured on acceptance and are don't-care afterwards.
- Quarter counter counts 0..CLK_DIV-1. All phase changes happen on its wrap.
- FSM states: IDLE, START, BIT, STOP, RESP.
- START (1Q): osck=1, osda=0.
- BIT (4Q per bit, quarters q0..q3):
  - osck is 0 in q0/q1 and 1 in q2/q3.
  - osda is updated at the start of q0.
  - isda is sampled on the last clk of q2.
- Bits go MSB first. 9 bits per byte. 9th bit: master releases osda and samples ACK (0=ACK). For the read data byte, the master drives osda=1 (NACK).
- STOP (4Q): q0 osck=0/osda=0; q1 osck=1/osda=0; q2 osck=1/osda=1; q3 bus-free idle.
- RESP (1 cycle): rsp_valid=1, then back to IDLE.
- Write sequence: START, {dev,0}, reg_adr, wdata, STOP, RESP. Takes 113Q clocks from acceptance to the rsp_valid cycle.
- Read sequence:
  - First transaction: START, {dev,0}, reg_adr, STOP.
  - Second transaction: START, {dev,1}, 8 data bits sampled into a shift register, NACK, STOP, RESP. Total 154Q clocks.
  - rsp_rdata is loaded at RESP.
  - STOP+START is used instead of a repeated START.
- NACK on any ACK slot: the remaining bytes of the transaction are skipped and the block goes straight to STOP then RESP with rsp_nack=1.
  - For a read, the second transaction is not issued and rsp_rdata is unchanged.
- cmd_valid asserted while busy is ignored and not queued.
- cmd_ready drops the cycle after acceptance. It reasserts the cycle after the rsp_valid pulse, so back-to-back commands are separated by at least 1 IDLE cycle.
- Quarter and bit counters cover the widths implied by CLK_DIV and 9 bits. No wrap occurs outside the defined sequences.

Test Plan:
- Reset: hold rstn=0 for 3 clk with cmd_valid=1 -> osck=osda=1, cmd_ready=1, rsp_valid=0, rsp_rdata=00.
- Write, CLK_DIV=16, dev=7'h10, reg=8'h03, wdata=8'hA5, behavioural slave ACKing -> bus bytes 0x20,0x03,0xA5. START/STOP edges occur with osck=1. rsp_valid pulses exactly 113*16 clk after acceptance with rsp_nack=0.
- Read, slave returns 8'h5C -> sequence 0x20,0x03,STOP,START,0x21. Master NACKs the 9th bit. rsp_rdata=5C, rsp_nack=0, latency 154*16 clk.
- Wrong address (slave never ACKs) -> after the first byte, STOP follows immediately. rsp_nack=1 with rsp_valid. Read data is unchanged.
- cmd_valid pulsed mid-transaction with different fields -> ignored. Bus bytes and response match the first command only.
- Reset asserted mid-data-byte of a write -> osck/osda=1 on the next edge with no STOP. A new write issued afterwards completes normally.
